// File: rtl/bankgroup_mb_pkg.sv
// bankgroup_mb_pkg: shared widths and defaults for the multi-bank SRAM group.
// The per-bank address and data widths are fixed by the 32x256 SRAM macro.
package bankgroup_mb_pkg;

  localparam int BG_BANK_AW   = 8;
  localparam int BG_DATA_W    = 32;
  localparam int BG_NUM_BANKS = 4;

  // Bank-select width; a single bank still carries one select bit so the
  // address layout {bank, word} never collapses to a zero-width field.
  function automatic int bg_bsel_w(input int num_banks);
    return (num_banks <= 1) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/bankgroup_mb_bank.sv
// bg_bank: one SRAM bank of the group. Converts the group's active-high
// select/write strobes into the macro's active-low csb/web pins; a bank that
// is not selected is held deselected with web=1.
import bankgroup_mb_pkg::*;

module bg_bank (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [BG_BANK_AW-1:0] addr,
  input  logic [BG_DATA_W-1:0]  din,
  output logic [BG_DATA_W-1:0]  dout
);

  logic csb;
  logic web;

  assign csb = ~cs;
  assign web = ~(cs & we);

  sram_1rw0r0w_32_256_freepdk45 u_sram (
    .clk0  (clk),
    .csb0  (csb),
    .web0  (web),
    .addr0 (addr),
    .din0  (din),
    .dout0 (dout)
  );

endmodule

// File: rtl/sram_1rw0r0w_32_256_freepdk45.sv
// sram_1rw0r0w_32_256_freepdk45: behavioural model of the single-port
// 32x256 SRAM macro. Active-low chip select and write enable; a selected
// read registers the addressed word on dout0 at the same rising edge.
module sram_1rw0r0w_32_256_freepdk45 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [7:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0
);

  logic [31:0] mem [256];

  // Single port: a selected cycle is either a write or a read, never both
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        mem[addr0] <= din0;
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

endmodule

// File: rtl/bankgroup_mb.sv
// bankgroup_mb: one registered request port feeding NUM_BANKS SRAM banks.
// The high address bits pick the bank; reads return on dout_bus = {valid, data}
// two edges after the request is sampled. Defining BG_OUT_REG_EN adds an
// output register after the bank mux (latency three, data held while idle).
import bankgroup_mb_pkg::*;

module bankgroup_mb #(
  parameter int NUM_BANKS = BG_NUM_BANKS,
  parameter int BANK_AW   = BG_BANK_AW,
  parameter int DATA_W    = BG_DATA_W,
  parameter int BSEL_W    = bg_bsel_w(NUM_BANKS),
  parameter int A_W       = BANK_AW + BSEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [A_W-1:0]    addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W:0]   dout_bus,
  output logic              busy_o
);

  logic [A_W-1:0]    s0_addr;
  logic [DATA_W-1:0] s0_din;
  logic              s0_en;
  logic              s0_we;
  logic [BSEL_W-1:0] s0_bank;
  logic [BANK_AW-1:0] s0_word;
  logic              s0_rd_v;

  logic              tag_v;
  logic [BSEL_W-1:0] tag_bank;

  logic              bank_cs   [NUM_BANKS];
  logic [DATA_W-1:0] bank_dout [NUM_BANKS];
  logic [DATA_W-1:0] mux_data;

  assign s0_bank = s0_addr[A_W-1:BANK_AW];
  assign s0_word = s0_addr[BANK_AW-1:0];
  assign s0_rd_v = s0_en & ~s0_we;

  // Input stage: capture every request; a simultaneous read and write is a pure read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_addr <= '0;
      s0_din  <= '0;
      s0_en   <= 1'b0;
      s0_we   <= 1'b0;
    end else begin
      s0_addr <= addr_i;
      s0_din  <= din_i;
      s0_en   <= en_i & (we_i | re_i);
      s0_we   <= we_i & ~re_i;
    end
  end

  // Read tag follows the access into the macro so the mux knows which bank answers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v    <= 1'b0;
      tag_bank <= '0;
    end else begin
      tag_v    <= s0_rd_v;
      tag_bank <= s0_bank;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_cs[b] = s0_en & (s0_bank == BSEL_W'(b));

    bg_bank u_bank (
      .clk  (clk),
      .cs   (bank_cs[b]),
      .we   (s0_we),
      .addr (s0_word),
      .din  (s0_din),
      .dout (bank_dout[b])
    );
  end

  // Bank mux steered by the tagged bank index
  always_comb begin
    mux_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (tag_bank == BSEL_W'(b)) begin
        mux_data = bank_dout[b];
      end
    end
  end

`ifdef BG_OUT_REG_EN
  logic              out_v;
  logic [DATA_W-1:0] out_data;

  // Output register: pulse valid for one cycle, keep the last read data while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v    <= 1'b0;
      out_data <= '0;
    end else begin
      out_v <= tag_v;
      if (tag_v) begin
        out_data <= mux_data;
      end
    end
  end

  assign dout_bus = {out_v, out_data};
  assign busy_o   = s0_rd_v | tag_v | out_v;
`else
  assign dout_bus = {tag_v, mux_data};
  assign busy_o   = s0_rd_v | tag_v;
`endif

endmodule

// File: tb/tb_bankgroup_mb.sv
// tb_bankgroup_mb: directed scenarios followed by random traffic, checked
// against a word-addressed memory model with a per-cycle schedule of
// expected read returns.
module tb_bankgroup_mb;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SLOTS = 4096;
`ifdef BG_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          rst_n;
  logic          en_i;
  logic          we_i;
  logic          re_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] din_i;
  logic [DW:0]   dout_bus;
  logic          busy_o;

  int total;
  int bad;
  int cyc;

  logic [DW-1:0] mem     [1 << AW];
  bit            written [1 << AW];

  bit            exp_v    [SLOTS];
  bit            exp_k    [SLOTS];
  logic [DW-1:0] exp_d    [SLOTS];
  bit            exp_busy [SLOTS];

  bit            hold_known;
  logic [DW-1:0] hold_val;

  bankgroup_mb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .we_i     (we_i),
    .re_i     (re_i),
    .addr_i   (addr_i),
    .din_i    (din_i),
    .dout_bus (dout_bus),
    .busy_o   (busy_o)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clearSchedule();
    for (int i = 0; i < SLOTS; i++) begin
      exp_v[i]    = 1'b0;
      exp_k[i]    = 1'b0;
      exp_d[i]    = '0;
      exp_busy[i] = 1'b0;
    end
  endtask

  task automatic checkCycle();
    checkOutput("valid", {31'd0, dout_bus[DW]}, {31'd0, exp_v[cyc]});
    checkOutput("busy", {31'd0, busy_o}, {31'd0, exp_busy[cyc]});
    if (exp_v[cyc] && exp_k[cyc]) begin
      checkOutput("data", dout_bus[DW-1:0], exp_d[cyc]);
    end
`ifdef BG_OUT_REG_EN
    if (exp_v[cyc]) begin
      hold_known = exp_k[cyc];
      hold_val   = exp_d[cyc];
    end else if (hold_known) begin
      checkOutput("hold", dout_bus[DW-1:0], hold_val);
    end
`endif
  endtask

  // One request per cycle; the model decides its outcome at request time
  task automatic applyStimulus(input bit en, input bit we, input bit re,
                               input logic [AW-1:0] addr, input logic [DW-1:0] din);
    en_i   = en;
    we_i   = we;
    re_i   = re;
    addr_i = addr;
    din_i  = din;
    if (en && (we || re)) begin
      if (re) begin
        exp_v[cyc + LAT] = 1'b1;
        exp_k[cyc + LAT] = written[addr];
        exp_d[cyc + LAT] = mem[addr];
        for (int t = 1; t <= LAT; t++) exp_busy[cyc + t] = 1'b1;
      end else begin
        mem[addr]     = din;
        written[addr] = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    checkCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    en_i  = 1'b0;
    we_i  = 1'b0;
    re_i  = 1'b0;
    #1;
    clearSchedule();
    hold_known = 1'b1;
    hold_val   = '0;
    checkOutput("rst_valid", {31'd0, dout_bus[DW]}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      checkOutput("rst_valid", {31'd0, dout_bus[DW]}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    end
`ifdef BG_OUT_REG_EN
    checkOutput("rst_data", dout_bus[DW-1:0], 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] pool [16];
    logic [AW-1:0] a;
    bit en, we, re;

    total = 0;
    bad   = 0;
    cyc   = 0;
    en_i = 0; we_i = 0; re_i = 0; addr_i = '0; din_i = '0;
    rst_n = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = '0;
      written[i] = 1'b0;
    end
    #2;
    doReset(3);

    // Two writes, then back-to-back reads from bank 0 and bank 3
    applyStimulus(1, 1, 0, 10'h005, 32'hDEADBEEF);
    applyStimulus(1, 1, 0, 10'h305, 32'hCAFEF00D);
    applyStimulus(1, 0, 1, 10'h005, 32'h0);
    applyStimulus(1, 0, 1, 10'h305, 32'h0);
    idle(5);

    // Read and write together: the read wins, memory untouched
    applyStimulus(1, 1, 0, 10'h105, 32'h11111111);
    applyStimulus(1, 1, 1, 10'h105, 32'h22222222);
    idle(3);
    applyStimulus(1, 0, 1, 10'h105, 32'h0);
    idle(4);

    // Read strobe without enable does nothing
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 10'h005, 32'h0);
    idle(2);

    // Write then immediate read of the same word
    applyStimulus(1, 1, 0, 10'h0FF, 32'hA5A5A5A5);
    applyStimulus(1, 0, 1, 10'h0FF, 32'h0);
    idle(4);

    // Read cut short by reset never returns
    applyStimulus(1, 0, 1, 10'h005, 32'h0);
    doReset(2);
    idle(5);

    // Random traffic over a small address pool spread across all banks
    for (int i = 0; i < 16; i++) pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, pool[i], $urandom);
    for (int i = 0; i < 400; i++) begin
      a  = pool[$urandom_range(0, 15)];
      en = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      re = $urandom_range(0, 1) == 1;
      applyStimulus(en, we, re, a, $urandom);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
